// File: rtl/morse_level_game.sv
// Per-difficulty Morse game engine: fetches targets from the pattern ROM,
// collects dot/dash entries, scores each round against a time limit, and
// raises logout_level when the game ends.
module morse_level_game #(
  parameter int unsigned NUM_ROUNDS = 5,
  parameter int unsigned ROM_BASE   = 0,
  parameter int unsigned ADDR_W     = 7,
  parameter int unsigned TIME_LIMIT = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              LoggedIn_level,
  input  logic              sec_tick,
  input  logic              dot_in,
  input  logic              dash_in,
  input  logic              submit,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [4:0]        target_pattern,
  output logic [2:0]        target_len,
  output logic [2:0]        round,
  output logic [3:0]        score,
  output logic [3:0]        time_left,
  output logic              correct,
  output logic              wrong,
  output logic              logout_level
);

  localparam int unsigned PAT_W = 5;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_PLAY  = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]        state_q,   state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [PAT_W-1:0]  pattern_q, pattern_d;
  logic [2:0]        tlen_q,    tlen_d;
  logic [2:0]        round_q,   round_d;
  logic [3:0]        score_q,   score_d;
  logic [3:0]        time_q,    time_d;
  logic              correct_q, correct_d;
  logic              wrong_q,   wrong_d;
  logic              logout_q,  logout_d;
  logic [PAT_W-1:0]  entry_q,   entry_d;
  logic [2:0]        elen_q,    elen_d;

  logic [PAT_W-1:0]  mask_c;
  logic              match_c;

  // Compare only the low target_len symbols; an empty target matches an empty entry.
  assign mask_c  = PAT_W'((6'd1 << tlen_q) - 6'd1);
  assign match_c = (elen_q == tlen_q) && ((entry_q & mask_c) == (pattern_q & mask_c));

  // Next-state and output-register logic.
  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    pattern_d  = pattern_q;
    tlen_d     = tlen_q;
    round_d    = round_q;
    score_d    = score_q;
    time_d     = time_q;
    correct_d  = 1'b0;
    wrong_d    = 1'b0;
    logout_d   = logout_q;
    entry_d    = entry_q;
    elen_d     = elen_q;

    if (state_q == S_IDLE || !LoggedIn_level) begin
      state_d    = (state_q == S_IDLE && LoggedIn_level) ? S_FETCH : S_IDLE;
      rom_addr_d = '0;
      pattern_d  = '0;
      tlen_d     = '0;
      round_d    = '0;
      score_d    = '0;
      time_d     = '0;
      logout_d   = 1'b0;
      entry_d    = '0;
      elen_d     = '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          rom_addr_d = ADDR_W'(ROM_BASE + {29'd0, round_q});
          state_d    = S_LATCH;
        end
        S_LATCH: begin
          pattern_d = rom_data[4:0];
          tlen_d    = (rom_data[7:5] > 3'd5) ? 3'd5 : rom_data[7:5];
          entry_d   = '0;
          elen_d    = '0;
          time_d    = 4'(TIME_LIMIT);
          state_d   = S_PLAY;
        end
        S_PLAY: begin
          if (submit) begin
            correct_d = match_c;
            wrong_d   = !match_c;
            if (match_c && score_q != 4'hF) score_d = score_q + 4'd1;
            state_d   = S_CHECK;
          end else if (sec_tick && time_q == 4'd1) begin
            time_d  = 4'd0;
            wrong_d = 1'b1;
            state_d = S_CHECK;
          end else begin
            if (sec_tick) time_d = time_q - 4'd1;
            if ((dot_in ^ dash_in) && elen_q < 3'd5) begin
              entry_d = entry_q | (PAT_W'(dash_in) << elen_q);
              elen_d  = elen_q + 3'd1;
            end
          end
        end
        S_CHECK: begin
          round_d = round_q + 3'd1;
          if (round_q + 3'd1 == 3'(NUM_ROUNDS)) begin
            logout_d = 1'b1;
            time_d   = 4'd0;
            state_d  = S_DONE;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_DONE: state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rom_addr_q <= '0;
      pattern_q  <= '0;
      tlen_q     <= '0;
      round_q    <= '0;
      score_q    <= '0;
      time_q     <= '0;
      correct_q  <= 1'b0;
      wrong_q    <= 1'b0;
      logout_q   <= 1'b0;
      entry_q    <= '0;
      elen_q     <= '0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      pattern_q  <= pattern_d;
      tlen_q     <= tlen_d;
      round_q    <= round_d;
      score_q    <= score_d;
      time_q     <= time_d;
      correct_q  <= correct_d;
      wrong_q    <= wrong_d;
      logout_q   <= logout_d;
      entry_q    <= entry_d;
      elen_q     <= elen_d;
    end
  end

  assign rom_addr       = rom_addr_q;
  assign target_pattern = pattern_q;
  assign target_len     = tlen_q;
  assign round          = round_q;
  assign score          = score_q;
  assign time_left      = time_q;
  assign correct        = correct_q;
  assign wrong          = wrong_q;
  assign logout_level   = logout_q;

endmodule

// File: tb/tb_morse_level_game.sv
// Bench for morse_level_game: two instances (1-round/TL=3 and 3-round/base 8/TL=5)
// sharing a pattern ROM and the player inputs, checked against a queue-based model.
module tb_morse_level_game;

  localparam int TL_A = 3;
  localparam int TL_B = 5;

  logic clk, rst, en_a, en_b, tick, dot, dash, sub;
  logic [7:0] rom [0:127];

  logic [6:0] ra_a, ra_b;
  logic [4:0] tp_a, tp_b;
  logic [2:0] tl_a, tl_b, rd_a, rd_b;
  logic [3:0] sc_a, sc_b, tm_a, tm_b;
  logic       co_a, co_b, wr_a, wr_b, lo_a, lo_b;
  logic [7:0] rd_data_a, rd_data_b;

  wire [28:0] all_a = {ra_a, tp_a, tl_a, rd_a, sc_a, tm_a, co_a, wr_a, lo_a};
  wire [28:0] all_b = {ra_b, tp_b, tl_b, rd_b, sc_b, tm_b, co_b, wr_b, lo_b};

  int total = 0;
  int bad   = 0;

  assign rd_data_a = rom[ra_a];
  assign rd_data_b = rom[ra_b];

  morse_level_game #(.NUM_ROUNDS(1), .ROM_BASE(0), .ADDR_W(7), .TIME_LIMIT(TL_A)) dut_a (
    .clk(clk), .rst(rst), .LoggedIn_level(en_a), .sec_tick(tick), .dot_in(dot),
    .dash_in(dash), .submit(sub), .rom_addr(ra_a), .rom_data(rd_data_a),
    .target_pattern(tp_a), .target_len(tl_a), .round(rd_a), .score(sc_a),
    .time_left(tm_a), .correct(co_a), .wrong(wr_a), .logout_level(lo_a));

  morse_level_game #(.NUM_ROUNDS(3), .ROM_BASE(8), .ADDR_W(7), .TIME_LIMIT(TL_B)) dut_b (
    .clk(clk), .rst(rst), .LoggedIn_level(en_b), .sec_tick(tick), .dot_in(dot),
    .dash_in(dash), .submit(sub), .rom_addr(ra_b), .rom_data(rd_data_b),
    .target_pattern(tp_b), .target_len(tl_b), .round(rd_b), .score(sc_b),
    .time_left(tm_b), .correct(co_b), .wrong(wr_b), .logout_level(lo_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got still running want finished");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic d, input logic h, input logic s, input logic t);
    dot = d; dash = h; sub = s; tick = t;
    step();
    dot = 1'b0; dash = 1'b0; sub = 1'b0; tick = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en_a = 1'b0; en_b = 1'b0;
    dot = 1'b0; dash = 1'b0; sub = 1'b0; tick = 1'b0;
    step(); step();
    rst = 1'b0;
    total++; if (all_a !== 29'd0) begin bad++; $display("FAIL reset_a: got %h want 0", all_a); end
    total++; if (all_b !== 29'd0) begin bad++; $display("FAIL reset_b: got %h want 0", all_b); end
  endtask

  task automatic test_single_correct();
    rom[0] = 8'b011_00010;
    en_a = 1'b1; step(); step(); step();
    total++; if ({tp_a, tl_a, tm_a} !== {5'b00010, 3'd3, 4'(TL_A)}) begin
      bad++; $display("FAIL sc_target: got %h want %h", {tp_a, tl_a, tm_a}, {5'b00010, 3'd3, 4'(TL_A)}); end
    drive(1, 0, 0, 0); drive(0, 1, 0, 0); drive(1, 0, 0, 0);
    drive(0, 0, 1, 0);
    total++; if ({co_a, wr_a} !== 2'b10) begin bad++; $display("FAIL sc_pulse: got %b want 10", {co_a, wr_a}); end
    step();
    total++; if ({lo_a, rd_a, sc_a, tm_a, co_a, wr_a} !== {1'b1, 3'd1, 4'd1, 4'd0, 2'b00}) begin
      bad++; $display("FAIL sc_done: got %h want %h", {lo_a, rd_a, sc_a, tm_a, co_a, wr_a}, {1'b1, 3'd1, 4'd1, 4'd0, 2'b00}); end
    drive(1, 0, 1, 1); step();
    total++; if ({lo_a, sc_a, rd_a} !== {1'b1, 4'd1, 3'd1}) begin
      bad++; $display("FAIL sc_hold: got %h want %h", {lo_a, sc_a, rd_a}, {1'b1, 4'd1, 3'd1}); end
    en_a = 1'b0; step();
    total++; if (all_a !== 29'd0) begin bad++; $display("FAIL sc_logout: got %h want 0", all_a); end
  endtask

  task automatic test_single_wrong();
    en_a = 1'b1; step(); step(); step();
    drive(1, 0, 0, 0); drive(1, 0, 0, 0); drive(1, 0, 0, 0);
    drive(0, 0, 1, 0);
    total++; if ({co_a, wr_a} !== 2'b01) begin bad++; $display("FAIL sw_pulse: got %b want 01", {co_a, wr_a}); end
    step();
    total++; if ({lo_a, sc_a, rd_a} !== {1'b1, 4'd0, 3'd1}) begin
      bad++; $display("FAIL sw_done: got %h want %h", {lo_a, sc_a, rd_a}, {1'b1, 4'd0, 3'd1}); end
    en_a = 1'b0; step();
  endtask

  task automatic test_timeout();
    en_a = 1'b1; step(); step(); step();
    total++; if (tm_a !== 4'd3) begin bad++; $display("FAIL to_start: got %0d want 3", tm_a); end
    for (int k = 2; k >= 0; k--) begin
      drive(0, 0, 0, 1);
      total++; if (tm_a !== 4'(k)) begin bad++; $display("FAIL to_time: got %0d want %0d", tm_a, k); end
    end
    total++; if ({co_a, wr_a} !== 2'b01) begin bad++; $display("FAIL to_pulse: got %b want 01", {co_a, wr_a}); end
    step();
    total++; if ({lo_a, sc_a} !== {1'b1, 4'd0}) begin bad++; $display("FAIL to_done: got %h want 10", {lo_a, sc_a}); end
    en_a = 1'b0; step();
  endtask

  task automatic test_same_cycle();
    rom[0] = 8'b001_00000;
    en_a = 1'b1; step(); step(); step();
    drive(1, 1, 0, 0);
    drive(1, 0, 0, 0);
    drive(0, 1, 1, 0);
    total++; if ({co_a, wr_a} !== 2'b10) begin bad++; $display("FAIL same_cycle: got %b want 10", {co_a, wr_a}); end
    en_a = 1'b0; step();
  endtask

  task automatic test_random_games();
    int exp_score, mode, len, ticks, n;
    int sym[$];
    int acc[$];
    logic [7:0] w;
    logic [4:0] pat;
    logic tk, hh, match;
    for (int g = 0; g < 6; g++) begin
      exp_score = 0;
      for (int r = 0; r < 3; r++) rom[8 + r] = 8'($urandom);
      en_b = 1'b1; step(); step(); step();
      for (int r = 0; r < 3; r++) begin
        w = rom[8 + r];
        len = (w[7:5] > 3'd5) ? 5 : int'(w[7:5]);
        pat = w[4:0];
        total++; if (ra_b !== 7'(8 + r)) begin bad++; $display("FAIL rg_addr: got %0d want %0d", ra_b, 8 + r); end
        total++; if ({tp_b, tl_b} !== {pat, 3'(len)}) begin
          bad++; $display("FAIL rg_target: got %h want %h", {tp_b, tl_b}, {pat, 3'(len)}); end
        total++; if ({rd_b, sc_b, tm_b} !== {3'(r), 4'(exp_score), 4'(TL_B)}) begin
          bad++; $display("FAIL rg_status: got %h want %h", {rd_b, sc_b, tm_b}, {3'(r), 4'(exp_score), 4'(TL_B)}); end
        mode = (g == 0) ? 0 : int'($urandom_range(0, 2));
        sym.delete(); acc.delete(); ticks = 0;
        if (mode == 0) begin
          for (int i = 0; i < len; i++) sym.push_back(int'(pat[i]));
        end else begin
          n = int'($urandom_range(0, 7));
          for (int i = 0; i < n; i++) sym.push_back(int'($urandom_range(0, 1)));
        end
        foreach (sym[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            tk = (ticks < TL_B - 1) && ($urandom_range(0, 2) == 0);
            hh = 1'($urandom_range(0, 1));
            drive(hh, hh, 1'b0, tk);
            if (tk) ticks++;
          end
          tk = (ticks < TL_B - 1) && ($urandom_range(0, 2) == 0);
          drive(sym[i] == 0, sym[i] == 1, 1'b0, tk);
          if (tk) ticks++;
          if (acc.size() < 5) acc.push_back(sym[i]);
        end
        total++; if (tm_b !== 4'(TL_B - ticks)) begin
          bad++; $display("FAIL rg_time: got %0d want %0d", tm_b, TL_B - ticks); end
        if (mode == 2) begin
          while (ticks < TL_B) begin
            ticks++;
            drive(ticks == TL_B, 1'b0, 1'b0, 1'b1);
          end
          match = 1'b0;
        end else begin
          drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
          match = (acc.size() == len);
          for (int i = 0; i < acc.size(); i++)
            if (match && acc[i] != int'(pat[i])) match = 1'b0;
        end
        total++; if ({co_b, wr_b} !== {match, ~match}) begin
          bad++; $display("FAIL rg_pulse: got %b want %b", {co_b, wr_b}, {match, ~match}); end
        if (match) exp_score++;
        step();
        if (r < 2) begin step(); step(); end
      end
      total++; if ({lo_b, rd_b, sc_b, tm_b} !== {1'b1, 3'd3, 4'(exp_score), 4'd0}) begin
        bad++; $display("FAIL rg_done: got %h want %h", {lo_b, rd_b, sc_b, tm_b}, {1'b1, 3'd3, 4'(exp_score), 4'd0}); end
      en_b = 1'b0; step();
      total++; if (all_b !== 29'd0) begin bad++; $display("FAIL rg_logout: got %h want 0", all_b); end
    end
  endtask

  task automatic test_abort();
    rom[8] = 8'b001_00000;
    rom[9] = 8'b010_00001;
    en_b = 1'b1; step(); step(); step();
    drive(1, 0, 0, 0);
    drive(0, 0, 1, 0);
    step(); step(); step();
    total++; if ({rd_b, sc_b, ra_b} !== {3'd1, 4'd1, 7'd9}) begin
      bad++; $display("FAIL ab_round2: got %h want %h", {rd_b, sc_b, ra_b}, {3'd1, 4'd1, 7'd9}); end
    en_b = 1'b0;
    drive(1, 0, 1, 0);
    total++; if (all_b !== 29'd0) begin bad++; $display("FAIL ab_clear: got %h want 0", all_b); end
    en_b = 1'b1; step(); step();
    total++; if ({ra_b, rd_b, sc_b} !== {7'd8, 3'd0, 4'd0}) begin
      bad++; $display("FAIL ab_restart: got %h want %h", {ra_b, rd_b, sc_b}, {7'd8, 3'd0, 4'd0}); end
    en_b = 1'b0; step();
  endtask

  task automatic test_reset_in_done();
    en_a = 1'b1; step(); step(); step();
    drive(0, 0, 1, 0);
    step();
    total++; if (lo_a !== 1'b1) begin bad++; $display("FAIL rd_done: got %b want 1", lo_a); end
    rst = 1'b1; step(); rst = 1'b0;
    total++; if (all_a !== 29'd0) begin bad++; $display("FAIL rd_clear: got %h want 0", all_a); end
    en_a = 1'b0; step();
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 8'(i * 37);
    test_reset();
    test_single_correct();
    test_single_wrong();
    test_timeout();
    test_same_cycle();
    test_random_games();
    test_abort();
    test_reset_in_done();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/morse_level_game.md
Name: morse_level_game

Overview:
- Per-difficulty game engine: the responder side of the difficulty selector's LoggedIn_<level>/logout_<level> handshake.
- Instantiated once per level (easy/medium/hard) with different ROM_BASE/TIME_LIMIT.
- When enabled, fetches NUM_ROUNDS Morse targets from the pattern ROM, collects dot/dash entries, scores each round against a per-round time limit, and asserts logout_level when the game ends.

Parameters:
- NUM_ROUNDS, 5, rounds per game (1..7).
- ROM_BASE, 0, first ROM address for this level.
- ADDR_W, 7, ROM address width.
- TIME_LIMIT, 10, seconds allowed per round (1..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- LoggedIn_level  in  1  enable from difficulty selector; level-sensitive.
- sec_tick  in  1  one-cycle pulse, once per second.
- dot_in  in  1  one-cycle pulse, debounced upstream.
- dash_in  in  1  one-cycle pulse, debounced upstream.
- submit  in  1  one-cycle pulse, debounced upstream.
- rom_addr  out  ADDR_W  pattern ROM address (registered).
- rom_data  in  8  {len[7:5], pattern[4:0]}; valid one cycle after rom_addr changes.
- target_pattern  out  5  current target; bit i = symbol i, 1=dash, 0=dot.
- target_len  out  3  current target length.
- round  out  3  rounds completed.
- score  out  4  correct rounds.
- time_left  out  4  seconds remaining in current round.
- correct  out  1  one-cycle pulse, round won.
- wrong  out  1  one-cycle pulse, round lost.
- logout_level  out  1  game finished; goes to selector's logout_<level>.

Behaviour:
- Reset: all outputs 0, state IDLE. rst has priority over everything.
- States: IDLE, FETCH, LATCH, PLAY, CHECK, DONE.
- IDLE
  - Outputs 0.
  - LoggedIn_level=1 -> FETCH; round=0, score=0.
- FETCH
  - rom_addr <= ROM_BASE+round -> LATCH.
- LATCH
  - Capture rom_data into target_pattern/target_len. len 6 or 7 is clamped to 5.
  - Clear entry buffer and entry_len; time_left=TIME_LIMIT -> PLAY.
- PLAY
  - dot_in/dash_in writes 0/1 at entry bit entry_len, then entry_len++.
  - Symbols are ignored when entry_len=5, or when dot_in and dash_in arrive together.
  - sec_tick decrements time_left.
  - submit -> CHECK.
  - Tick that takes time_left 1->0 -> CHECK with forced mismatch (timeout).
  - Same-cycle priority: submit > timeout > symbol. A symbol arriving with submit or timeout is dropped.
- CHECK (1 cycle)
  - match = (entry_len==target_len) AND (entry[len-1:0]==pattern[len-1:0]) AND not timeout. len 0 matches only an empty submit.
  - match: correct=1 and score+1, saturating at 15. Otherwise wrong=1.
  - round+1.
  - If new round==NUM_ROUNDS -> DONE, else -> FETCH.
  - Total latency submit -> correct/wrong pulse: 1 cycle (pulse in cycle after submit sampled).
- DONE
  - logout_level=1, held.
  - score, round, target frozen; time_left=0.
  - Inputs ignored.
  - LoggedIn_level=0 -> IDLE (logout_level drops same edge).
- LoggedIn_level=0 in any non-IDLE state -> IDLE next edge; all outputs cleared; no correct/wrong pulse.
- Re-enable after abort starts a fresh game from round 0.
- Pulses correct/wrong are never simultaneous; at most one per round.
- rom_addr is held stable outside FETCH.

Test Plan:
- ROM[0]=8'b011_00010 (dot,dash,dot), NUM_ROUNDS=1. Enable, then dot, dash, dot, submit. Expect:
  - correct pulse 1 cycle after submit.
  - score=1, round=1.
  - logout_level=1 held until LoggedIn_level=0, then all outputs 0.
- Same ROM, enter dot,dot,dot then submit -> wrong pulse, score=0, logout_level=1.
- TIME_LIMIT=3. Enter nothing, apply 3 sec_ticks -> wrong pulse on cycle after 3rd tick; time_left sequence 3,2,1,0.
- Same cycle stimulus:
  - submit and dash_in together with entry matching "dot" target (len 1) -> dash dropped, correct pulse.
  - dot_in and dash_in together -> entry_len unchanged.
- NUM_ROUNDS=3, ROM_BASE=8. Expect:
  - rom_addr visits 8, 9, 10.
  - 3 correct answers -> score=3, round=3, logout_level=1.
  - Then drop LoggedIn_level -> IDLE.
- Abort and reset cases:
  - Drop LoggedIn_level mid-PLAY in round 2 -> next cycle all outputs 0, no pulse; re-enable restarts at rom_addr=ROM_BASE.
  - rst=1 during DONE -> outputs 0 on next edge.
